pipe_hazard_ctrl: RTL

- Central sequencing controller for the 5-stage pipeline registers (PC, FD, DE, EM, MW).
- Computes the stall, bubble and flush enables each cycle from the register-file hazards (Tuse/Tnew) and from multiply/divide unit occupancy.
- Also handles ERET/EPC ordering and exception (Req) priority.
- Owns the multiply/divide busy countdown so that no other stage has to track unit occupancy.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 20 ++
 rtl/pipe_hazard_ctrl_md_busy_cnt.sv | 57 +++++
 rtl/pipe_hazard_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  // A Tuse of 3 marks an operand that is never read.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Default multiply/divide unit occupancy after issue.
  localparam int MULT_LAT_DEFAULT = 5;
  localparam int DIV_LAT_DEFAULT  = 10;
  localparam int CNT_W_DEFAULT    = 4;

  // Exception handler entry point loaded by the pipeline registers on Req.
  localparam logic [31:0] EXCPC = 32'h0000_4180;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_cnt.sv
// Multiply/divide unit occupancy tracker: IDLE/BUSY FSM plus a busy down-counter.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   MD_IDLE | unit free, counter is 0
//   MD_BUSY | unit occupied; leaves when the counter reaches 1
module pipe_hazard_ctrl_md_busy_cnt
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEFAULT,
  parameter int DIV_LAT  = DIV_LAT_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  input  logic i_is_div,
  output logic o_busy
);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // State and counter registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: a start always (re)loads the latency, so the last start wins.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (i_start) begin
      w_state_nxt = MD_BUSY;
      w_cnt_nxt   = i_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (r_state == MD_BUSY) begin
      if (r_cnt == CNT_W'(1)) begin
        w_state_nxt = MD_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
    end
  end

  // Busy is visible in the start cycle itself; forced low while in reset.
  assign o_busy = ((r_state == MD_BUSY) | i_start) & ~i_reset;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall / bubble / flush sequencing for the 5-stage pipeline.
// Optional stall statistics counters are built when PIPE_STALL_STAT_EN is defined.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEFAULT,
  parameter int DIV_LAT  = DIV_LAT_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT   // must hold max(MULT_LAT, DIV_LAT)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic [4:0]  E_waddr,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_waddr,
  input  logic [1:0]  M_tnew,
  input  logic        D_is_md,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  input  logic        D_eret,
  input  logic        E_mtc0_epc,
  input  logic        M_mtc0_epc,
  input  logic        Req,
`ifdef PIPE_STALL_STAT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] md_stall_cnt,
`endif
  output logic        PC_en,
  output logic        FD_en,
  output logic        FD_clr,
  output logic        DE_clr,
  output logic        md_busy,
  output logic        md_start_ok
);

  logic w_rs_stall;
  logic w_rt_stall;
  logic w_reg_stall;
  logic w_md_stall;
  logic w_epc_stall;
  logic w_stall_raw;
  logic w_stall;
  logic w_md_busy;
  logic w_md_start_ok;

  // Register hazards: a producer in E or M whose result arrives too late.
  always_comb begin
    w_rs_stall = 1'b0;
    w_rt_stall = 1'b0;
    if (D_rs_addr != 5'd0 && D_tuse_rs != TUSE_NONE) begin
      w_rs_stall = ((D_rs_addr == E_waddr) && (E_tnew > D_tuse_rs)) ||
                   ((D_rs_addr == M_waddr) && (M_tnew > D_tuse_rs));
    end
    if (D_rt_addr != 5'd0 && D_tuse_rt != TUSE_NONE) begin
      w_rt_stall = ((D_rt_addr == E_waddr) && (E_tnew > D_tuse_rt)) ||
                   ((D_rt_addr == M_waddr) && (M_tnew > D_tuse_rt));
    end
  end

  assign w_reg_stall   = w_rs_stall | w_rt_stall;
  assign w_md_start_ok = E_md_start & ~Req & ~reset;
  assign w_md_stall    = D_is_md & w_md_busy;
  assign w_epc_stall   = D_eret & (E_mtc0_epc | M_mtc0_epc);
  assign w_stall_raw   = w_reg_stall | w_md_stall | w_epc_stall;
  // Req outranks every hazard: the pipeline flushes to EXCPC instead.
  assign w_stall       = w_stall_raw & ~Req & ~reset;

  pipe_hazard_ctrl_md_busy_cnt #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_busy_cnt (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_start  (w_md_start_ok),
    .i_is_div (E_md_is_div),
    .o_busy   (w_md_busy)
  );

  assign PC_en       = ~w_stall;
  assign FD_en       = ~w_stall;
  assign DE_clr      = w_stall;
  assign FD_clr      = D_eret & ~w_stall_raw & ~Req & ~reset;
  assign md_busy     = w_md_busy;
  assign md_start_ok = w_md_start_ok;

`ifdef PIPE_STALL_STAT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_md_stall_cnt;

  // Stall statistics; w_stall already excludes Req and reset cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt    <= '0;
      r_md_stall_cnt <= '0;
    end else begin
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_stall && w_md_stall && !w_reg_stall && !w_epc_stall) begin
        r_md_stall_cnt <= r_md_stall_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt    = r_stall_cnt;
  assign md_stall_cnt = r_md_stall_cnt;
`endif

endmodule
